fp_normalizer_rne: RTL and testbench
====================================

# fp_normalizer_rne

Parametrised floating-point normalise-and-round stage with valid/ready flow control. Takes the sign, the larger operand exponent and the raw extended mantissa produced by the adder/multiplier datapath of the DQN accelerator, and emits a packed IEEE-754-style word with status flags. It is the successor of the fixed FP32, 2-stage normaliser. It adds generic widths, guard bits, round-to-nearest-even, underflow flushing, overflow-to-infinity and backpressure.

## Interface
- `EXP_W`, 8: exponent width.
- `MAN_W`, 23: stored fraction width.
- `GRD_W`, 3: extra low bits below the fraction LSB (guard, round, sticky; ≥2).
- `clk`  in  1: clock.
- `rstn`  in  1: reset. Asynchronous assert, active-low.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: block accepts input this cycle.
- `in_sign`  in  1: result sign.
- `in_exp`  in  EXP_W: biased larger exponent.
- `in_mant`  in  M = MAN_W+2+GRD_W: {carry, hidden, fraction[MAN_W], guard[GRD_W]}.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts result.
- `out_data`  out  1+EXP_W+MAN_W: {sign, exp, fraction}.
- `out_ovf`  out  1: result overflowed to infinity.
- `out_unf`  out  1: nonzero result flushed to zero.
- `out_inexact`  out  1: discarded bits were nonzero.

## Operation
- 3-stage pipeline. Global advance enable is `en = !out_valid || out_ready`, and `in_ready = en`. When `en=0` every stage holds; bubbles are not collapsed.
- **S1, classify/LZC:**
  - `in_exp == EXP_MAX` (all ones) → class INF.
  - `in_mant == 0` → class ZERO.
  - `in_mant[M-1]` set → class CARRY.
  - Otherwise → class NORM, with `lz` = number of zeros above the leading one, counted from bit M-2.
- **S2, shift:**
  - CARRY: shift right 1; exponent +1; the bit shifted out is ORed into sticky.
  - NORM with `lz < in_exp`: shift left `lz`; exponent −`lz`.
  - NORM with `lz ≥ in_exp`: flush. Result is signed zero and `unf=1`. No subnormals are produced.
  - ZERO: signed zero; `unf=0`.
  - INF: exponent EXP_MAX, fraction 0.
- **S3, round/pack:**
  - g = guard MSB; s = OR of the remaining guard bits (plus any carry sticky).
  - `inexact = g | s`. It is 0 for INF, ZERO and flush cases.
  - Rounding is per the macro (see Configuration).
  - If the fraction carries out after the increment, the fraction becomes 0 and the exponent +1.
  - If the final exponent equals EXP_MAX, the output is signed infinity (fraction 0) with `ovf=1`. An INF input gives `ovf=0`.
- Sign passes through unchanged in every case, including zero.
- All arithmetic on the exponent is done at EXP_W+1 bits to detect wrap. Exponent 0 on input with a nonzero mantissa is treated as a flush.

## Timing
- Latency is 3 cycles from an accepted input (`in_valid & in_ready`) to `out_valid`, with `out_ready` held high. Throughput is 1/cycle.
- `out_valid` stays asserted and `out_data`/flags stay stable until `out_ready` is sampled high.
- On `rstn` low, all stage valids, `out_valid`, `out_data`, `out_ovf`, `out_unf` and `out_inexact` clear to 0 immediately, discarding in-flight data. `in_ready` is 1 during and after reset.
- Simultaneous accept and emit in one cycle is permitted (steady-state streaming).
- Data registers load only when their stage advances with a valid input.

## Configuration
- `FP_NORM_ROUND_EN` defined: round-to-nearest-even. Round up when `g & (s | lsb)`.
- Not defined: truncate. The fraction is never incremented; `inexact` is still reported. Latency is unchanged (S3 remains a register stage).

## Structure
- Package `fp_norm_pkg`:
  - Class enum {NORM, CARRY, ZERO, INF}.
  - Function `exp_max(EXP_W)`.
  - Width helper `mant_w(MAN_W, GRD_W)`.
- Sub-module `fp_lzc`: parametrised combinational leading-zero counter of width M−1, output width `$clog2(M)`, instantiated in S1.

## Test plan
All cases use defaults: EXP_W=8, MAN_W=23, GRD_W=3, M=28. Bit 27 is carry, bit 26 is hidden, bits 25:3 are fraction, bits 2:0 are guard.
- exp 127, mant `28'h4000000`, sign 0 → `3F800000`, flags 0, out_valid 3 cycles later. Exp 127, mant `28'h8000000` → `40000000`. Exp 127, mant `28'h2000000` → `3F000000`.
- Rounding: exp 127, mant `28'h400000C` → `3F800002`, inexact 1 with the macro; `3F800001`, inexact 1 without. Exp 127, mant `28'h7FFFFFC` with the macro → `40000000` (fraction carry-out).
- Specials:
  - sign 1, mant 0 → `80000000`, unf 0.
  - exp 255 → `7F800000`, ovf 0.
  - exp 254, mant `28'h8000000` → `7F800000`, ovf 1.
  - exp 3, mant `28'h0000100` → `00000000`, unf 1.
- Backpressure: stream 6 values with `out_ready` toggling 1,0,0,1 → in_ready tracks en, no loss or duplication, outputs in order and stable while stalled.
- Reset mid-stream: assert `rstn` low with 3 words in flight → out_valid 0 immediately, no stale word emitted after release; the next input produces its correct result after 3 cycles.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared classes and width helpers for the normalise/round pipeline
package fp_norm_pkg;
  typedef enum logic [1:0] {NORM, CARRY, ZERO, INF} cls_e;
  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction
  function automatic int mant_w(input int mw, input int gw);
    return mw + 2 + gw;
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter, returns W when the input is zero
module fp_lzc #(
  parameter int W = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);
  // highest set bit wins because later iterations overwrite earlier ones
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) if (d[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_normalizer_rne.sv
// fp_normalizer_rne: 3-stage normalise/round/pack; FP_NORM_ROUND_EN selects RNE, else truncate
module fp_normalizer_rne
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRD_W = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W-1:0]         in_exp,
  input  logic [MAN_W+GRD_W+1:0]   in_mant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic                     out_ovf,
  output logic                     out_unf,
  output logic                     out_inexact
);
  localparam int M = mant_w(MAN_W, GRD_W);
  localparam int LW = $clog2(M);
  localparam logic [EXP_W-1:0] EMAX = EXP_W'(exp_max(EXP_W));
  logic en;
  logic [LW-1:0] lz;
  cls_e cls_in;
  logic v1, sign1;
  logic [EXP_W-1:0] exp1;
  logic [M-1:0] mant1;
  logic [LW-1:0] lz1;
  cls_e cls1;
  logic flush;
  logic [M-3:0] sh;
  logic [EXP_W:0] e2n;
  logic v2, sign2, zero2, unf2, inf2;
  logic [EXP_W:0] exp2;
  logic [M-3:0] man2;
  logic g, s, rup, ovf_n, inex_n;
  logic [MAN_W:0] fr;
  logic [EXP_W:0] e3;
  logic [EXP_W+MAN_W:0] data_n;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  fp_lzc #(.W(M - 1), .CW(LW)) u_lzc (.d(in_mant[M-2:0]), .cnt(lz));
  // S1 classification; INF takes priority over every mantissa pattern
  always_comb
    cls_in = in_exp == EMAX ? INF : in_mant == '0 ? ZERO : in_mant[M-1] ? CARRY : NORM;
  // S2 alignment: carry shifts right with sticky kept in bit 0, normals shift left by lz
  always_comb begin
    flush = (cls1 == NORM && (EXP_W+1)'(lz1) >= {1'b0, exp1}) || (cls1 == CARRY && exp1 == '0);
    sh = cls1 == CARRY ? {mant1[M-2:2], mant1[1] | mant1[0]} : (M-2)'(mant1 << lz1);
    e2n = cls1 == CARRY ? {1'b0, exp1} + (EXP_W+1)'(1) : {1'b0, exp1} - (EXP_W+1)'(lz1);
  end
  assign g = man2[GRD_W-1];
  assign s = |man2[GRD_W-2:0];
`ifdef FP_NORM_ROUND_EN
  assign rup = g & (s | man2[GRD_W]);
`else
  assign rup = 1'b0;
`endif
  assign fr = {1'b0, man2[M-3:GRD_W]} + (MAN_W+1)'(rup);
  assign e3 = exp2 + (EXP_W+1)'(fr[MAN_W]);
  // S3 pack: a fraction carry-out leaves fr low bits zero, so only the exponent moves
  always_comb begin
    ovf_n = !inf2 && !zero2 && e3 >= {1'b0, EMAX};
    inex_n = !inf2 && !zero2 && (g | s);
    data_n = inf2 || ovf_n ? {sign2, EMAX, {MAN_W{1'b0}}} :
             zero2 ? {sign2, {(EXP_W+MAN_W){1'b0}}} : {sign2, e3[EXP_W-1:0], fr[MAN_W-1:0]};
  end
  // pipeline registers: all stages advance together on en, data only on valid
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      v1 <= 1'b0; sign1 <= 1'b0; exp1 <= '0; mant1 <= '0; lz1 <= '0; cls1 <= NORM;
      v2 <= 1'b0; sign2 <= 1'b0; zero2 <= 1'b0; unf2 <= 1'b0; inf2 <= 1'b0; exp2 <= '0; man2 <= '0;
      out_valid <= 1'b0; out_data <= '0; out_ovf <= 1'b0; out_unf <= 1'b0; out_inexact <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      if (in_valid) begin
        sign1 <= in_sign; exp1 <= in_exp; mant1 <= in_mant; lz1 <= lz; cls1 <= cls_in;
      end
      if (v1) begin
        sign2 <= sign1; zero2 <= cls1 == ZERO || flush; unf2 <= flush; inf2 <= cls1 == INF;
        exp2 <= e2n; man2 <= sh;
      end
      if (v2) begin
        out_data <= data_n; out_ovf <= ovf_n; out_unf <= zero2 && unf2; out_inexact <= inex_n;
      end
    end
endmodule

// File: tb/tb_fp_normalizer_rne.sv
// tb_fp_normalizer_rne: random + directed bench against a value-level RNE reference model
module tb_fp_normalizer_rne;
  logic clk = 0, rstn = 0;
  logic in_valid = 0, in_sign = 0, out_ready = 1;
  logic [7:0] in_exp = 0;
  logic [27:0] in_mant = 0;
  logic in_ready, out_valid, out_ovf, out_unf, out_inexact;
  logic [31:0] out_data;
  int n_cmp = 0, n_bad = 0;
  logic [34:0] q[$];
  logic held_v = 0;
  logic [34:0] held;
  logic done;

  fp_normalizer_rne dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // value-level model: exact remainder compared against one half ulp
  function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [27:0] m);
    int p, ex;
    longint x, sig, rem;
    logic inx, up;
    if (e == 8'hFF) return {s, 8'hFF, 23'h0, 3'b000};
    if (m == 0) return {s, 31'h0, 3'b000};
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    ex = int'(e) + p - 26;
    if (e == 0 || ex <= 0) return {s, 31'h0, 3'b010};
    x = longint'(m) << 8;
    x = p == 27 ? x >> 1 : x << (26 - p);
    sig = x >> 11;
    rem = x & 2047;
    inx = rem != 0;
`ifdef FP_NORM_ROUND_EN
    up = rem > 1024 || (rem == 1024 && sig[0]);
`else
    up = 1'b0;
`endif
    sig = sig + longint'(up);
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      ex++;
    end
    if (ex >= 255) return {s, 8'hFF, 23'h0, 2'b10, inx};
    return {s, 8'(ex), sig[22:0], 2'b00, inx};
  endfunction

  // scoreboard: record accepted inputs, check emitted words, order and stall stability
  always @(negedge clk) begin
    if (rstn) begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && held_v) chk("stable", {out_data, out_ovf, out_unf, out_inexact}, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", 1, 0);
        else chk("out", {out_data, out_ovf, out_unf, out_inexact}, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(in_sign, in_exp, in_mant));
      held_v = out_valid && !out_ready;
      held = {out_data, out_ovf, out_unf, out_inexact};
    end else held_v = 0;
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
    int n = 0;
    in_valid = 1; in_sign = s; in_exp = e; in_mant = m;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic direct(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                        input logic [34:0] want);
    int n = 0;
    send(s, e, m);
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk({tag, "_lat"}, n, 3);
    chk(tag, {out_data, out_ovf, out_unf, out_inexact}, want);
    @(posedge clk); #1;
  endtask

  task automatic rnd_word(output logic s, output logic [7:0] e, output logic [27:0] m);
    int k = $urandom_range(0, 7);
    s = 1'($urandom);
    m = 28'($urandom) >> $urandom_range(0, 27);
    e = 8'($urandom_range(1, 254));
    if (k == 0) m = 0;
    if (k == 1) e = 8'hFF;
    if (k == 2) e = 8'($urandom_range(0, 5));
    if (k == 3) begin e = 8'($urandom_range(250, 254)); m = 28'($urandom) | 28'h8000000; end
    if (k == 4) m = (28'($urandom) | 28'h4000000) & 28'h7FFFFFF;
  endtask

  initial begin
    logic pat[4];
    logic s;
    logic [7:0] e;
    logic [27:0] m;
    int k, n;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ready", in_ready, 1);
    rstn = 1;
    @(posedge clk); #1;
    direct("one", 0, 127, 28'h4000000, {32'h3F800000, 3'b000});
    direct("neg_one", 1, 127, 28'h4000000, {32'hBF800000, 3'b000});
    direct("carry", 0, 127, 28'h8000000, {32'h40000000, 3'b000});
    direct("half", 0, 127, 28'h2000000, {32'h3F000000, 3'b000});
`ifdef FP_NORM_ROUND_EN
    direct("rne_up", 0, 127, 28'h400000C, {32'h3F800002, 3'b001});
    direct("frac_co", 0, 127, 28'h7FFFFFC, {32'h40000000, 3'b001});
`else
    direct("trunc", 0, 127, 28'h400000C, {32'h3F800001, 3'b001});
    direct("trunc_co", 0, 127, 28'h7FFFFFC, {32'h3FFFFFFF, 3'b001});
`endif
    direct("neg_zero", 1, 100, 28'h0, {32'h80000000, 3'b000});
    direct("inf_in", 0, 255, 28'h4000000, {32'h7F800000, 3'b000});
    direct("ovf", 0, 254, 28'h8000000, {32'h7F800000, 3'b100});
    direct("flush", 0, 3, 28'h0000100, {32'h00000000, 3'b010});
    direct("exp0", 1, 0, 28'h4000000, {32'h80000000, 3'b010});
    // backpressure: six words while out_ready cycles 1,0,0,1
    done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin rnd_word(s, e, m); send(s, e, m); end
        done = 1;
      end
      begin
        k = 0;
        while (!done) begin out_ready = pat[k % 4]; k++; @(posedge clk); #1; end
      end
    join
    out_ready = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("bp_drain", q.size(), 0);
    // random streaming with random gaps and random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          rnd_word(s, e, m);
          send(s, e, m);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1;
      end
      begin
        while (!done) begin out_ready = $urandom_range(0, 2) != 0; @(posedge clk); #1; end
      end
    join
    out_ready = 1;
    n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("rnd_drain", q.size(), 0);
    // reset with three words in flight
    send(0, 127, 28'h4000000);
    send(1, 130, 28'h8000000);
    send(0, 100, 28'h2000000);
    rstn = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ready", in_ready, 1);
    q.delete();
    @(posedge clk); #1;
    rstn = 1;
    repeat (5) begin @(negedge clk); chk("stale", out_valid, 0); end
    @(posedge clk); #1;
    direct("post_rst", 0, 128, 28'h4000000, {32'h40000000, 3'b000});
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
